// File: rtl/alu_op_issue_if.sv
// ----------------------------------------------------------------------------
// alu_op_issue_if
//   Bundles the two streaming handshakes of the ALU issue stage.
//   Input stream : in_valid/in_ready carrying {in_sel, in_a, in_b}
//   Output stream: out_valid/out_ready carrying {out_y, out_sel, out_zero}
//   master : the environment (drives ops upstream, sinks results downstream)
//   slave  : the issue block
// ----------------------------------------------------------------------------
interface alu_op_issue_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_sel;
   logic [3:0] in_a;
   logic [3:0] in_b;

   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_y;
   logic [3:0] out_sel;
   logic       out_zero;

   modport master (
      output in_valid, in_sel, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_y, out_sel, out_zero
   );

   modport slave (
      input  in_valid, in_sel, in_a, in_b, out_ready,
      output in_ready, out_valid, out_y, out_sel, out_zero
   );
endinterface

// File: rtl/alu_op_issue.sv
// ----------------------------------------------------------------------------
// alu_op_issue
//   Issue stage in front of a 4-bit combinational ALU. Ops are buffered in a
//   DEPTH-entry FIFO, moved into a registered issue slot that drives the ALU
//   inputs, and the ALU's 5-bit result is captured into a registered result
//   slot together with its select code and a zero flag. Strict in-order.
//
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     bus (slave)  : in_valid/in_ready/in_sel/in_a/in_b and
//                    out_valid/out_ready/out_y/out_sel/out_zero
//     alu_a/b/sel  : registered ALU operands and select (issue slot)
//     alu_y        : combinational ALU result for the current alu_*
//     count        : FIFO occupancy, issue and result slots not included
//
//   DEPTH must be a power of two and at least 2 so the pointers wrap on
//   their own; count carries one extra bit to tell full from empty.
// ----------------------------------------------------------------------------
module alu_op_issue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_op_issue_if.slave          bus,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [3:0]             alu_sel,
   input  logic [4:0]             alu_y,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] a;
      logic [3:0] b;
   } op_t;

   op_t           mem [DEPTH];
   op_t           in_op;
   op_t           head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          push;
   logic          iss_v;
   logic          res_adv;
   logic          iss_load;

   // ------------------------------------------------------------------------
   // Handshake decode. in_ready depends only on registered count so it has
   // no combinational path from in_valid or out_ready.
   // ------------------------------------------------------------------------
   assign in_op        = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
   assign bus.in_ready = (count != CW'(DEPTH));
   assign push         = bus.in_valid && bus.in_ready;

   // The result slot takes a new result whenever it is empty or being
   // drained this cycle; the issue slot refills whenever it is empty or its
   // op is moving into the result slot.
   assign res_adv  = iss_v && (!bus.out_valid || bus.out_ready);
   assign iss_load = (count != '0) && (!iss_v || res_adv);

   assign head = mem[rd_ptr];

   // ------------------------------------------------------------------------
   // FIFO storage: data only, no reset needed since count gates every read.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_op;
   end

   // ------------------------------------------------------------------------
   // FIFO pointers and occupancy. Push and pop in the same cycle leave count
   // unchanged; a push is never seen when full because in_ready is low.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + AW'(1);
         if (iss_load) rd_ptr <= rd_ptr + AW'(1);
         case ({push, iss_load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Issue slot. alu_* hold their last values while the slot is empty so
   // the ALU inputs do not toggle needlessly.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_v   <= 1'b0;
         alu_sel <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
      end else if (iss_load) begin
         iss_v   <= 1'b1;
         alu_sel <= head.sel;
         alu_a   <= head.a;
         alu_b   <= head.b;
      end else if (res_adv) begin
         iss_v   <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Result slot. Captured fields stay frozen while out_valid && !out_ready,
   // and also hold once the slot empties.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_y     <= '0;
         bus.out_sel   <= '0;
         bus.out_zero  <= 1'b0;
      end else if (res_adv) begin
         bus.out_valid <= 1'b1;
         bus.out_y     <= alu_y;
         bus.out_sel   <= alu_sel;
         bus.out_zero  <= (alu_y == 5'b00000);
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_issue.sv
// ----------------------------------------------------------------------------
// tb_alu_op_issue
//   Bench for alu_op_issue. A stand-in combinational ALU feeds alu_y. The
//   reference model is an in-order queue of expected {sel, y} pairs filled
//   on every accepted op and drained on every consumed result; one negedge
//   process compares the DUT against it each cycle. Directed sequences add
//   hand-computed literal expectations for latency, capacity and reset.
// ----------------------------------------------------------------------------
module tb_alu_op_issue;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_issue_if bus();

   logic [3:0]             alu_a, alu_b, alu_sel;
   logic [4:0]             alu_y;
   logic [$clog2(DEPTH):0] count;

   alu_op_issue #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_sel (alu_sel),
      .alu_y   (alu_y),
      .count   (count)
   );

   // Stand-in ALU: signed arithmetic when sel[3]=0, logical when sel[3]=1,
   // 4-bit results sign-extended to 5 bits.
   function automatic logic [4:0] alu_f(input logic [3:0] s, a, b);
      logic [4:0] sa, sb, r;
      logic [3:0] l;
      sa = {a[3], a};
      sb = {b[3], b};
      l  = 4'h0;
      r  = 5'h00;
      case (s)
         4'h0: r = sa;
         4'h1: r = sa - 5'd1;
         4'h2: r = sa + 5'd1;
         4'h3: r = -sa;
         4'h4: r = sa - sb;
         4'h5: r = sb - sa;
         4'h6: r = sa + sb;
         4'h7: r = sa + sb + 5'd1;
         default: begin
            case (s[2:0])
               3'd0: l = ~a;
               3'd1: l = ~b;
               3'd2: l = a & b;
               3'd3: l = a | b;
               3'd4: l = a ^ b;
               3'd5: l = ~(a & b);
               3'd6: l = ~(a | b);
               default: l = ~(a ^ b);
            endcase
            r = {l[3], l};
         end
      endcase
      return r;
   endfunction

   assign alu_y = alu_f(alu_sel, alu_a, alu_b);

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model and per-cycle compare
   // ------------------------------------------------------------------------
   typedef struct {
      logic [3:0] sel;
      logic [4:0] y;
   } exp_t;

   exp_t       q[$];
   int         accepted  = 0;
   int         delivered = 0;
   logic       prev_hold = 1'b0;
   logic [4:0] prev_y;
   logic [3:0] prev_sel;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         prev_hold = 1'b0;
      end else begin
         chk("count_le_depth", 32'(count <= DEPTH), 1);
         chk("in_ready_vs_count", bus.in_ready, 32'(count != DEPTH));
         if (prev_hold) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_y", bus.out_y, prev_y);
            chk("hold_sel", bus.out_sel, prev_sel);
         end
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: got y=%0h with no op outstanding (t=%0t)", bus.out_y, $time);
            end else begin
               chk("out_y", bus.out_y, q[0].y);
               chk("out_sel", bus.out_sel, q[0].sel);
               chk("out_zero", bus.out_zero, 32'(q[0].y == 5'd0));
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  delivered++;
               end
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_y    = bus.out_y;
         prev_sel  = bus.out_sel;
         if (bus.in_valid && bus.in_ready) begin
            e.sel = bus.in_sel;
            e.y   = alu_f(bus.in_sel, bus.in_a, bus.in_b);
            q.push_back(e);
            accepted++;
         end
         chk("capacity", 32'(q.size() <= DEPTH + 2), 1);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic drive(input logic v, input logic [3:0] s, a, b);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_a     = a;
      bus.in_b     = b;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  bus.in_ready, 1);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_count"},     count, 0);
      chk({tag, "_alu_a"},     alu_a, 0);
      chk({tag, "_alu_b"},     alu_b, 0);
      chk({tag, "_alu_sel"},   alu_sel, 0);
      chk({tag, "_out_y"},     bus.out_y, 0);
      chk({tag, "_out_sel"},   bus.out_sel, 0);
      chk({tag, "_out_zero"},  bus.out_zero, 0);
   endtask

   // One op into an empty pipe; result checked after the second edge past acceptance.
   task automatic one_op(input string name, input logic [3:0] s, a, b,
                         input logic [4:0] ey, input logic ez);
      step();
      drive(1'b1, s, a, b);
      step();
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      repeat (3) @(negedge clk);
      chk({name, "_valid"}, bus.out_valid, 1);
      chk({name, "_y"},     bus.out_y, ey);
      chk({name, "_sel"},   bus.out_sel, s);
      chk({name, "_zero"},  bus.out_zero, ez);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n, cyc, a0, d0;
      logic acc;

      drive(1'b0, 4'h0, 4'h0, 4'h0);
      bus.out_ready = 1'b1;

      // Reset and first cycle after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_reset_vals("reset");

      // Single op: latency 2 edges from acceptance
      step();
      drive(1'b1, 4'b0110, 4'b0011, 4'b0100);
      step();
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("single_after_n_valid", bus.out_valid, 0);
      chk("single_after_n_count", count, 1);
      @(negedge clk);
      chk("single_after_n1_valid", bus.out_valid, 0);
      chk("single_after_n1_alu_sel", alu_sel, 4'b0110);
      chk("single_after_n1_count", count, 0);
      @(negedge clk);
      chk("single_valid", bus.out_valid, 1);
      chk("single_y", bus.out_y, 5'b00111);
      chk("single_sel", bus.out_sel, 4'b0110);
      chk("single_zero", bus.out_zero, 0);

      // Signed and logical ops
      one_op("dec_neg", 4'b0001, 4'b1000, 4'b0000, 5'b10111, 1'b0);
      one_op("not_a",   4'b1000, 4'b0000, 4'b0000, 5'b11111, 1'b0);
      one_op("and_z",   4'b1010, 4'b1010, 4'b0101, 5'b00000, 1'b1);

      // Backpressure fill: ops are a+1 with a=1..n, so op k yields k+1
      step();
      bus.out_ready = 1'b0;
      n = 0;
      repeat (10) begin
         drive(1'b1, 4'b0110, 4'(n + 1), 4'd1);
         @(negedge clk);
         acc = bus.in_ready;
         step();
         if (acc) n++;
      end
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("fill_accepts", n, DEPTH + 2);
      chk("fill_in_ready", bus.in_ready, 0);
      chk("fill_count", count, DEPTH);
      chk("fill_out_valid", bus.out_valid, 1);
      chk("fill_out_y_op1", bus.out_y, 5'd2);
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_in_ready_not_comb", bus.in_ready, 0);
      chk("drain_first_y", bus.out_y, 5'd2);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("drain_valid", bus.out_valid, 1);
         chk("drain_y", bus.out_y, 5'(k + 2));
         if (k == 1) chk("drain_in_ready_rise", bus.in_ready, 1);
      end
      @(negedge clk);
      chk("drain_empty", bus.out_valid, 0);

      // Streaming 20 ops back to back
      step();
      drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
      for (int j = 1; j <= 24; j++) begin
         step();
         if (j < 20) drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
         else        drive(1'b0, 4'h0, 4'h0, 4'h0);
         @(negedge clk);
         chk("stream_valid", bus.out_valid, 32'(j >= 3 && j <= 22));
      end

      // Random in_valid/out_ready over 1000 ops
      a0 = accepted;
      d0 = delivered;
      n = 0;
      cyc = 0;
      step();
      while (n < 1000 && cyc < 20000) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));
         bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc) n++;
         cyc++;
      end
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      bus.out_ready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 50) begin
         step();
         cyc++;
      end
      @(negedge clk);
      chk("random_accepts", n, 1000);
      chk("random_drained", q.size(), 0);
      chk("random_no_loss", delivered - d0, accepted - a0);
      chk("random_final_valid", bus.out_valid, 0);
      chk("random_final_count", count, 0);

      // Reset mid-stream with FIFO at 3 and a held result
      step();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'b1011, 4'(i), 4'h3);
         step();
      end
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("pre_reset_count", count, 3);
      chk("pre_reset_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step();
      drive(1'b1, 4'b0100, 4'd5, 4'd3);
      step();
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("post_reset_n_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("post_reset_n1_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("post_reset_valid", bus.out_valid, 1);
      chk("post_reset_y", bus.out_y, 5'b00010);
      chk("post_reset_sel", bus.out_sel, 4'b0100);
      @(negedge clk);
      chk("post_reset_only_one", bus.out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
